// File: rtl/bshift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready on both sides.
// Define BSHIFT_ROTATE_EN to enable rotate operations selected by the rot input.
module bshift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             lr,
  input  logic             al,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input int amt,
                                                  input logic left, input logic arith);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    if (left)       shift_step = d << amt;
    else if (arith) shift_step = sd >>> amt;
    else            shift_step = d >> amt;
  endfunction

`ifdef BSHIFT_ROTATE_EN
  function automatic logic [WIDTH-1:0] rotate_step(input logic [WIDTH-1:0] d, input int amt,
                                                   input logic left);
    if (left) rotate_step = (d << amt) | (d >> (WIDTH - amt));
    else      rotate_step = (d >> amt) | (d << (WIDTH - amt));
  endfunction
`endif

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] data_p [SHW];
  logic [SHW-1:0]   sh_p   [SHW];
  logic             vld_p  [SHW];
  logic             lr_p   [SHW];
  logic             al_p   [SHW];
`ifdef BSHIFT_ROTATE_EN
  logic             rot_p  [SHW];
`else
  logic             rot_unused;
  assign rot_unused = rot;
`endif

  // A stalled consumer freezes every stage, so nothing can be overwritten or lost.
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld_p[SHW-1];
  assign dout      = data_p[SHW-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_sh;
    logic             src_vld;
    logic             src_lr;
    logic             src_al;
`ifdef BSHIFT_ROTATE_EN
    logic             src_rot;
`endif

    if (k == 0) begin : g_head
      assign src_data = din;
      assign src_sh   = shamt;
      assign src_vld  = in_valid;
      assign src_lr   = lr;
      assign src_al   = al;
`ifdef BSHIFT_ROTATE_EN
      assign src_rot  = rot;
`endif
    end else begin : g_tail
      assign src_data = data_p[k-1];
      assign src_sh   = sh_p[k-1];
      assign src_vld  = vld_p[k-1];
      assign src_lr   = lr_p[k-1];
      assign src_al   = al_p[k-1];
`ifdef BSHIFT_ROTATE_EN
      assign src_rot  = rot_p[k-1];
`endif
    end

    // Stage k boundary: apply the 2^k shift when shamt[k] is set.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p[k]  <= 1'b0;
        data_p[k] <= '0;
        sh_p[k]   <= '0;
        lr_p[k]   <= 1'b0;
        al_p[k]   <= 1'b0;
`ifdef BSHIFT_ROTATE_EN
        rot_p[k]  <= 1'b0;
`endif
      end else if (advance) begin
        vld_p[k] <= src_vld;
        sh_p[k]  <= src_sh;
        lr_p[k]  <= src_lr;
        al_p[k]  <= src_al;
`ifdef BSHIFT_ROTATE_EN
        rot_p[k] <= src_rot;
`endif
        if (!src_sh[k])
          data_p[k] <= src_data;
`ifdef BSHIFT_ROTATE_EN
        else if (src_rot)
          data_p[k] <= rotate_step(src_data, 1 << k, src_lr);
`endif
        else
          data_p[k] <= shift_step(src_data, 1 << k, src_lr, src_al);
      end
    end
  end

endmodule

// File: doc/bshift_pipe.md
Name: bshift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Next generation of the 8-bit combinational mux-tree shifter.
- Performs logical/arithmetic left/right shifts and, optionally, rotates on a WIDTH-bit operand.
- Uses one register stage per shift-amount bit, with a valid/ready handshake on both sides.
- Sits between an operand source (switches/regfile) and a consumer (display/ALU writeback) that may stall.

Parameters:
- WIDTH, 8, operand width; power of two, >= 2.
- SHW, $clog2(WIDTH), shift-amount width; also the number of pipeline stages.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- din  in  WIDTH  operand.
- shamt  in  SHW  shift amount, 0..WIDTH-1.
- lr  in  1  direction: 1 = left, 0 = right.
- al  in  1  1 = arithmetic, 0 = logical.
- rot  in  1  1 = rotate; ignored when the feature is compiled out.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  consumer accepts the result this cycle.
- dout  out  WIDTH  shifted result.

Behaviour:
- Reset (synchronous, active-high):
  - All stage valid bits cleared, all stage data/control registers cleared to 0.
  - out_valid = 0, dout = 0.
  - in_ready = 1 from the first cycle after reset.
- Pipeline stages:
  - Stage k (k = 0..SHW-1) registers the operand after conditionally shifting it by 2^k when shamt[k] = 1.
  - Stage k carries the remaining shamt bits plus lr/al/rot alongside the data.
- Latency:
  - An operand accepted in cycle t (in_valid & in_ready) appears on dout with out_valid = 1 in cycle t+SHW, absent stalls.
  - WIDTH = 8 gives 3 cycles.
- Throughput: one operand per cycle.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage register holds, and dout/out_valid stay stable.
  - No bubble compression; bubbles (invalid slots) advance normally when not stalled.
- Handshake: transfer occurs only on valid & ready. Operands are never dropped, duplicated or reordered.
- Fill rules:
  - Right logical: fill with 0.
  - Right arithmetic: fill with din[WIDTH-1] (sign bit carried through all stages).
  - Left, either al value: fill with 0 (arithmetic left = logical left).
  - rot = 1 (feature enabled): bits shifted out re-enter at the opposite end; al is ignored.
- shamt = 0: dout = din after SHW cycles.
- shamt = WIDTH-1: maximum shift, result is well defined by the fill rules.
- Simultaneous events:
  - Input accept and output consume in the same cycle are both honoured.
  - The pipeline advances by one slot.
- Reset mid-operation: all in-flight operands are discarded. out_valid = 0 in the cycle after rst is sampled high.

Optional Feature:
- Macro BSHIFT_ROTATE_EN.
- Defined: rot = 1 selects rotate in the chosen direction.
- Undefined:
  - The rot port still exists but is ignored; the operation is a plain shift per lr/al.
  - No rotate mux logic is synthesised.

Test Plan:
- WIDTH=8, din=8'h96, shamt=3, lr=0, al=1 -> dout=8'hF2 with out_valid exactly 3 cycles after accept.
- din=8'h96, shamt=3, lr=0, al=0 -> dout=8'h12. Same operand with lr=1, shamt=5 -> dout=8'hC0. shamt=0 -> dout=8'h96.
- Rotate, din=8'h96, shamt=3, lr=1, rot=1:
  - BSHIFT_ROTATE_EN defined -> dout=8'hB4.
  - Undefined -> dout=8'hB0.
  - Rotate right by 1, enabled -> 8'h4B.
- Back-to-back stream 8'h01, 8'h02, 8'h04, 8'h08 (shamt=1, lr=1), with out_ready low for 2 cycles once the first result is valid:
  - in_ready = 0 during the stall; dout holds 8'h02.
  - Outputs 02, 04, 08, 10 appear in order, with none lost.
- Assert rst with two operands in flight -> out_valid = 0 and dout = 0 next cycle; neither operand ever emerges; in_ready = 1 after reset.
- Random in_valid/out_ready toggling, 1000 operands -> scoreboard matches a reference shift model; zero mismatches.
